// File: rtl/hmmm_core_if.sv
`default_nettype none
// ============================================================================
// Module      : hmmm_core_if
// Description : Unified instruction/data memory port of the HMMM core.
//               The core drives request, direction, address and store data;
//               the memory returns read data and a ready strobe that
//               completes the current request.
// Revision    : 1.0 - initial release
// ============================================================================
interface hmmm_core_if #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
);
    localparam int RA_W    = $clog2(NREGS);
    localparam int INSTR_W = 4 + RA_W + DATA_W;

    logic                mem_req;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_adr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [INSTR_W-1:0]  mem_rdata;
    logic                mem_ready;

    // Core side: issues requests, consumes read data and ready
    modport master (
        output mem_req,
        output mem_we,
        output mem_adr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    // Memory side: serves requests
    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_adr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/hmmm_core.sv
`default_nettype none
// ============================================================================
// Module      : hmmm_core
// Description : Parametrised multi-cycle HMMM processor. One clock, FETCH /
//               EXEC / MEM / HALT sequencing over a single unified memory
//               port with a ready-based stall handshake. Retire strobe
//               instr_done pulses in the last cycle of every instruction.
//               Optional feature macro: HMMM_CORE_R0_ZERO_EN
//                 defined   -> register 0 reads as zero, writes discarded
//                 undefined -> register 0 is an ordinary register
// Revision    : 1.0 - initial release
// ============================================================================
module hmmm_core #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8
) (
    input  wire          clk,
    input  wire          reset_n,
    hmmm_core_if.master  mem,
    output logic         halted,
    output logic         instr_done
);

    localparam int RA_W    = $clog2(NREGS);
    localparam int INSTR_W = 4 + RA_W + DATA_W;

    localparam logic [DATA_W-1:0] c_one = {{(DATA_W-1){1'b0}}, 1'b1};

    // Opcodes (upper four instruction bits)
    localparam logic [3:0] c_op_halt   = 4'b0000;
    localparam logic [3:0] c_op_setn   = 4'b0001;
    localparam logic [3:0] c_op_storer = 4'b0010;
    localparam logic [3:0] c_op_loadr  = 4'b0011;
    localparam logic [3:0] c_op_copy   = 4'b0100;
    localparam logic [3:0] c_op_neg    = 4'b0101;
    localparam logic [3:0] c_op_add    = 4'b0110;
    localparam logic [3:0] c_op_sub    = 4'b0111;
    localparam logic [3:0] c_op_jeqzn  = 4'b1000;
    localparam logic [3:0] c_op_jneqzn = 4'b1001;
    localparam logic [3:0] c_op_jgtzn  = 4'b1010;
    localparam logic [3:0] c_op_jltzn  = 4'b1011;

    // Reject parameter sets the instruction format cannot encode
    generate
        if ((DATA_W < 4) || (NREGS < 2) || ((1 << RA_W) != NREGS) ||
            (DATA_W < 2 * RA_W)) begin : g_param_check
            $error("hmmm_core: illegal DATA_W/NREGS combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_regs [NREGS];

    // Instruction fields
    logic [3:0]          w_funct;
    logic [RA_W-1:0]     w_rd;
    logic [DATA_W-1:0]   w_imm;
    logic [RA_W-1:0]     w_ra;
    logic [RA_W-1:0]     w_rb;

    // Register read ports
    logic [DATA_W-1:0]   w_rd_val;
    logic [DATA_W-1:0]   w_ra_val;
    logic [DATA_W-1:0]   w_rb_val;

    // Execute results
    logic                w_alu_we;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_taken;
    logic [DATA_W-1:0]   w_target;
    logic [DATA_W-1:0]   w_pc_inc;
    logic                w_is_halt;
    logic                w_is_mem;
    logic                w_is_load;
    logic                w_is_store;

    // Control from the FSM
    logic                w_req;
    logic                w_we;
    logic [DATA_W-1:0]   w_adr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_done;
    logic                w_ir_load;
    logic                w_pc_load;
    logic [DATA_W-1:0]   w_pc_nxt;
    logic                w_wr_en_raw;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_wr_data;

    assign w_funct = r_ir[INSTR_W-1 -: 4];
    assign w_rd    = r_ir[DATA_W +: RA_W];
    assign w_imm   = r_ir[DATA_W-1:0];
    assign w_ra    = w_imm[DATA_W-1 -: RA_W];
    assign w_rb    = w_imm[DATA_W-RA_W-1 -: RA_W];

    assign w_is_halt  = (w_funct == c_op_halt);
    assign w_is_store = (w_funct == c_op_storer);
    assign w_is_load  = (w_funct == c_op_loadr);
    assign w_is_mem   = w_is_store | w_is_load;

    // PC increment wraps naturally from all-ones to zero
    assign w_pc_inc = r_pc + c_one;

`ifdef HMMM_CORE_R0_ZERO_EN
    // Register 0 is hard-wired to zero: reads return 0, writes are dropped
    assign w_rd_val = (w_rd == '0) ? '0 : r_regs[w_rd];
    assign w_ra_val = (w_ra == '0) ? '0 : r_regs[w_ra];
    assign w_rb_val = (w_rb == '0) ? '0 : r_regs[w_rb];
    assign w_wr_en  = w_wr_en_raw & (w_rd != '0);
`else
    assign w_rd_val = r_regs[w_rd];
    assign w_ra_val = r_regs[w_ra];
    assign w_rb_val = r_regs[w_rb];
    assign w_wr_en  = w_wr_en_raw;
`endif

    // ALU: register-writing operations resolved in EXEC
    always_comb begin
        w_alu_we  = 1'b0;
        w_alu_res = '0;
        case (w_funct)
            c_op_setn: begin
                w_alu_we  = 1'b1;
                w_alu_res = w_imm;
            end
            c_op_copy: begin
                w_alu_we  = 1'b1;
                w_alu_res = w_rb_val;
            end
            c_op_neg: begin
                w_alu_we  = 1'b1;
                w_alu_res = '0 - w_rb_val;
            end
            c_op_add: begin
                w_alu_we  = 1'b1;
                w_alu_res = w_ra_val + w_rb_val;
            end
            c_op_sub: begin
                w_alu_we  = 1'b1;
                w_alu_res = w_ra_val - w_rb_val;
            end
            default: begin
                w_alu_we  = 1'b0;
                w_alu_res = '0;
            end
        endcase
    end

    // Branch resolution: condition is tested on R[rd], target is imm or R[rd]
    always_comb begin
        w_taken  = 1'b0;
        w_target = w_imm;
        case (w_funct)
            c_op_jeqzn:  w_taken = (w_rd_val == '0);
            c_op_jneqzn: w_taken = (w_rd_val != '0);
            c_op_jgtzn:  w_taken = ~w_rd_val[DATA_W-1] & (w_rd_val != '0);
            c_op_jltzn:  w_taken = w_rd_val[DATA_W-1];
            4'b1100, 4'b1101: w_taken = 1'b1;
            4'b1110, 4'b1111: begin
                w_taken  = 1'b1;
                w_target = w_rd_val;
            end
            default: w_taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-state control
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_adr       = '0;
        w_wdata     = '0;
        w_done      = 1'b0;
        w_ir_load   = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_nxt    = w_pc_inc;
        w_wr_en_raw = 1'b0;
        w_wr_data   = w_alu_res;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                w_adr = r_pc;
                if (mem.mem_ready) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_halt) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_HALT;
                end else if (w_is_mem) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_done      = 1'b1;
                    w_pc_load   = 1'b1;
                    w_wr_en_raw = w_alu_we;
                    if (w_taken) begin
                        w_pc_nxt = w_target;
                    end
                    w_state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                // Address and data come from registers that cannot change
                // until the access completes, so they hold across stalls
                w_req   = 1'b1;
                w_we    = w_is_store;
                w_adr   = w_rb_val;
                w_wdata = w_rd_val;
                if (mem.mem_ready) begin
                    w_done      = 1'b1;
                    w_pc_load   = 1'b1;
                    w_wr_en_raw = w_is_load;
                    w_wr_data   = mem.mem_rdata[DATA_W-1:0];
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // PC and instruction register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= '0;
            r_ir <= '0;
        end else begin
            if (w_ir_load) begin
                r_ir <= mem.mem_rdata;
            end
            if (w_pc_load) begin
                r_pc <= w_pc_nxt;
            end
        end
    end

    // Register file: one write port, sources read before the write lands
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[w_rd] <= w_wr_data;
        end
    end

    // Outputs are forced quiet while reset is asserted, abandoning any request
    assign mem.mem_req   = reset_n & w_req;
    assign mem.mem_we    = reset_n & w_we;
    assign mem.mem_adr   = reset_n ? w_adr   : '0;
    assign mem.mem_wdata = reset_n ? w_wdata : '0;
    assign halted        = reset_n & (r_state == S_HALT);
    assign instr_done    = reset_n & w_done;

endmodule
`default_nettype wire

// File: tb/tb_hmmm_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_hmmm_core
// Description : Directed self-checking bench for hmmm_core with a behavioural
//               unified memory. Addresses 0x20 and above can be given
//               programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hmmm_core;
    localparam int DATA_W  = 8;
    localparam int NREGS   = 8;
    localparam int INSTR_W = 15;

    localparam logic [3:0] F_HALT   = 4'd0;
    localparam logic [3:0] F_SETN   = 4'd1;
    localparam logic [3:0] F_STORER = 4'd2;
    localparam logic [3:0] F_LOADR  = 4'd3;
    localparam logic [3:0] F_COPY   = 4'd4;
    localparam logic [3:0] F_NEG    = 4'd5;
    localparam logic [3:0] F_ADD    = 4'd6;
    localparam logic [3:0] F_SUB    = 4'd7;
    localparam logic [3:0] F_JEQZN  = 4'd8;
    localparam logic [3:0] F_JNEQZN = 4'd9;
    localparam logic [3:0] F_JGTZN  = 4'd10;
    localparam logic [3:0] F_JLTZN  = 4'd11;
    localparam logic [3:0] F_JUMPR  = 4'd14;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic halted;
    logic instr_done;

    hmmm_core_if #(.DATA_W(DATA_W), .NREGS(NREGS)) bus ();

    hmmm_core #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem        (bus.master),
        .halted     (halted),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    logic [INSTR_W-1:0] mem [256];
    int wait_n = 0;
    int wcnt   = 0;

    assign bus.mem_rdata = mem[bus.mem_adr];
    assign bus.mem_ready = bus.mem_req && ((bus.mem_adr < 8'h20) || (wcnt >= wait_n));

    // Wait-state counter: restarts whenever a request completes or drops
    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pa     = 0;
    int done_cyc [$];
    logic [7:0] rd_adr [$];
    logic [7:0] st_adr [$];
    logic [7:0] st_dat [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] op(input logic [3:0] f, input logic [2:0] rd, input logic [7:0] imm);
        return {f, rd, imm};
    endfunction

    function automatic logic [7:0] rr(input logic [2:0] ra, input logic [2:0] rb);
        return {ra, rb, 2'b00};
    endfunction

    task automatic emit(input logic [14:0] w);
        mem[pa] = w;
        pa++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        pa = 0;
    endtask

    task automatic clear_log();
        done_cyc.delete();
        rd_adr.delete();
        st_adr.delete();
        st_dat.delete();
        cyc = 0;
    endtask

    // One clock cycle, observed at the falling edge; completed stores land here
    task automatic cycle();
        if (instr_done) done_cyc.push_back(cyc + 1);
        if (bus.mem_req && bus.mem_we) begin
            st_adr.push_back(bus.mem_adr);
            st_dat.push_back(bus.mem_wdata);
        end
        if (bus.mem_req && bus.mem_ready) begin
            if (bus.mem_we) mem[bus.mem_adr] = {7'b0, bus.mem_wdata};
            else rd_adr.push_back(bus.mem_adr);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic start();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        clear_log();
    endtask

    task automatic run(input int max);
        while (!halted && cyc < max) cycle();
        check("halt_reached", halted, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] exp_r1;

        // ---- Basic program, reset values, 2-cycle latencies ----
        clear_mem();
        emit(op(F_SETN, 3'd1, 8'd5));
        emit(op(F_SETN, 3'd2, 8'd3));
        emit(op(F_SUB,  3'd3, rr(3'd1, 3'd2)));
        emit(op(F_HALT, 3'd0, 8'd0));
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req",    bus.mem_req,   0);
        check("rst_mem_we",     bus.mem_we,    0);
        check("rst_mem_adr",    bus.mem_adr,   0);
        check("rst_mem_wdata",  bus.mem_wdata, 0);
        check("rst_halted",     halted,        0);
        check("rst_instr_done", instr_done,    0);
        reset_n = 1'b1;
        #1;
        clear_log();
        check("first_fetch_req", bus.mem_req, 1);
        check("first_fetch_adr", bus.mem_adr, 0);
        run(50);
        check("p1_cycles", cyc, 8);
        check("p1_retired", done_cyc.size(), 4);
        for (int i = 0; i < 4; i++) check("p1_done_cycle", done_cyc[i], 2 * (i + 1));
        check("p1_req_after_halt", bus.mem_req, 0);
        cycle();
        check("p1_halt_sticky", halted, 1);
        reset_n = 1'b0;
        #1;
        check("halted_gated_by_reset", halted, 0);

        // ---- Arithmetic, aliasing and conditional branches ----
        clear_mem();
        emit(op(F_SETN, 3'd1, 8'd5));
        emit(op(F_SETN, 3'd2, 8'd3));
        emit(op(F_SUB,  3'd3, rr(3'd1, 3'd2)));
        emit(op(F_SETN, 3'd7, 8'h40));
        emit(op(F_STORER, 3'd3, rr(3'd0, 3'd7)));
        emit(op(F_SETN, 3'd1, 8'hFF));
        emit(op(F_SETN, 3'd2, 8'h02));
        emit(op(F_ADD,  3'd3, rr(3'd1, 3'd2)));
        emit(op(F_SETN, 3'd7, 8'h41));
        emit(op(F_STORER, 3'd3, rr(3'd0, 3'd7)));
        emit(op(F_SETN, 3'd4, 8'h00));
        emit(op(F_SETN, 3'd5, 8'h55));
        emit(op(F_NEG,  3'd5, rr(3'd0, 3'd4)));
        emit(op(F_SETN, 3'd7, 8'h42));
        emit(op(F_STORER, 3'd5, rr(3'd0, 3'd7)));
        emit(op(F_NEG,  3'd6, rr(3'd0, 3'd1)));
        emit(op(F_SETN, 3'd7, 8'h43));
        emit(op(F_STORER, 3'd6, rr(3'd0, 3'd7)));
        emit(op(F_SUB,  3'd3, rr(3'd2, 3'd1)));
        emit(op(F_SETN, 3'd7, 8'h44));
        emit(op(F_STORER, 3'd3, rr(3'd0, 3'd7)));
        emit(op(F_ADD,  3'd1, rr(3'd1, 3'd1)));
        emit(op(F_SETN, 3'd7, 8'h45));
        emit(op(F_STORER, 3'd1, rr(3'd0, 3'd7)));
        emit(op(F_SETN, 3'd6, 8'h80));
        emit(op(F_SETN, 3'd7, 8'h46));
        emit(op(F_JLTZN, 3'd6, 8'(pa + 2)));
        emit(op(F_STORER, 3'd6, rr(3'd0, 3'd7)));
        emit(op(F_SETN, 3'd7, 8'h47));
        emit(op(F_JGTZN, 3'd4, 8'(pa + 2)));
        emit(op(F_STORER, 3'd7, rr(3'd0, 3'd7)));
        emit(op(F_SETN, 3'd7, 8'h48));
        emit(op(F_JEQZN, 3'd4, 8'(pa + 2)));
        emit(op(F_STORER, 3'd7, rr(3'd0, 3'd7)));
        emit(op(F_SETN, 3'd7, 8'h49));
        emit(op(F_JNEQZN, 3'd4, 8'(pa + 2)));
        emit(op(F_STORER, 3'd7, rr(3'd0, 3'd7)));
        emit(op(F_HALT, 3'd0, 8'd0));
        start();
        run(400);
        check("sub_5_minus_3",        mem[8'h40], 32'h02);
        check("add_ff_plus_02",       mem[8'h41], 32'h01);
        check("neg_of_zero",          mem[8'h42], 32'h00);
        check("neg_of_ff",            mem[8'h43], 32'h01);
        check("sub_wraps",            mem[8'h44], 32'h03);
        check("add_rd_aliases_src",   mem[8'h45], 32'hFE);
        check("jltzn_80_taken",       mem[8'h46], 32'h00);
        check("jgtzn_00_not_taken",   mem[8'h47], 32'h47);
        check("jeqzn_00_taken",       mem[8'h48], 32'h00);
        check("jneqzn_00_not_taken",  mem[8'h49], 32'h49);

        // ---- Store with three wait cycles, then load back ----
        clear_mem();
        emit(op(F_SETN, 3'd5, 8'h20));
        emit(op(F_SETN, 3'd4, 8'h7E));
        emit(op(F_STORER, 3'd4, rr(3'd0, 3'd5)));
        emit(op(F_LOADR,  3'd1, rr(3'd0, 3'd5)));
        emit(op(F_SETN, 3'd7, 8'h30));
        emit(op(F_STORER, 3'd1, rr(3'd0, 3'd7)));
        emit(op(F_HALT, 3'd0, 8'd0));
        wait_n = 3;
        start();
        run(200);
        wait_n = 0;
        check("stall_store_done_cycle", done_cyc[2], 10);
        check("stall_load_done_cycle",  done_cyc[3], 16);
        check("stall_write_cycles",     st_adr.size(), 8);
        for (int i = 0; i < 4; i++) begin
            check("stall_store_adr",   st_adr[i], 32'h20);
            check("stall_store_wdata", st_dat[i], 32'h7E);
        end
        check("store_landed", mem[8'h20], 32'h7E);
        check("load_back",    mem[8'h30], 32'h7E);

        // ---- JUMPR and PC wrap at all-ones ----
        clear_mem();
        mem[8'h00] = op(F_JNEQZN, 3'd2, 8'h50);
        mem[8'h01] = op(F_SETN, 3'd6, 8'h10);
        mem[8'h02] = op(F_JUMPR, 3'd6, 8'h00);
        mem[8'h10] = op(F_SETN, 3'd6, 8'hFF);
        mem[8'h11] = op(F_JUMPR, 3'd6, 8'h00);
        mem[8'hFF] = op(F_SETN, 3'd2, 8'h33);
        mem[8'h50] = op(F_HALT, 3'd0, 8'h00);
        start();
        run(100);
        begin
            logic [7:0] exp_fetch [8] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'hFF, 8'h00, 8'h50};
            check("jump_fetch_count", rd_adr.size(), 8);
            for (int i = 0; i < 8; i++) check("jump_fetch_adr", rd_adr[i], exp_fetch[i]);
        end

        // ---- Reset during a stalled load ----
        clear_mem();
        emit(op(F_SETN, 3'd7, 8'h30));
        emit(op(F_STORER, 3'd1, rr(3'd0, 3'd7)));
        emit(op(F_SETN, 3'd2, 8'h20));
        emit(op(F_LOADR, 3'd1, rr(3'd0, 3'd2)));
        emit(op(F_SETN, 3'd7, 8'h31));
        emit(op(F_STORER, 3'd1, rr(3'd0, 3'd7)));
        emit(op(F_HALT, 3'd0, 8'd0));
        mem[8'h20] = 15'h005A;
        wait_n = 5;
        start();
        k = 0;
        while (!(bus.mem_req && !bus.mem_we && bus.mem_adr == 8'h20) && k < 60) begin
            cycle();
            k++;
        end
        check("load_wait_reached", bus.mem_req && !bus.mem_we && bus.mem_adr == 8'h20, 1);
        cycle();
        cycle();
        check("load_still_waiting", bus.mem_ready, 0);
        reset_n = 1'b0;
        #1;
        check("abort_req_dropped", bus.mem_req, 0);
        check("abort_adr_zero",    bus.mem_adr, 0);
        @(posedge clk);
        @(negedge clk);
        mem[8'h30] = 15'h00EE;
        wait_n = 0;
        reset_n = 1'b1;
        #1;
        clear_log();
        run(100);
        check("abort_first_fetch_adr", rd_adr[0], 0);
        check("abort_r1_unchanged",    mem[8'h30], 0);
        check("abort_reload",          mem[8'h31], 32'h5A);

        // ---- Register 0 behaviour ----
        clear_mem();
        emit(op(F_SETN, 3'd0, 8'd9));
        emit(op(F_COPY, 3'd1, rr(3'd0, 3'd0)));
        emit(op(F_SETN, 3'd7, 8'h30));
        emit(op(F_STORER, 3'd1, rr(3'd0, 3'd7)));
        emit(op(F_HALT, 3'd0, 8'd0));
        start();
        run(100);
`ifdef HMMM_CORE_R0_ZERO_EN
        exp_r1 = 32'd0;
`else
        exp_r1 = 32'd9;
`endif
        check("r0_copy", mem[8'h30], exp_r1);
        check("r0_retired", done_cyc.size(), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
